// File: rtl/fpau_pkg.sv
// Shared FPAU constants and the multiply/divide control state encoding.
package fpau_pkg;

  localparam int MANT_W   = 24;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] FP_NAN     = 32'h7FFFFFFF;
  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;
  localparam logic [31:0] FP_ZERO    = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/checkspecial.sv
// IEEE single operand classifier; denormals report as zero so they flush.
module checkspecial (
  input  logic [31:0] x,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero
);

  logic exp_max;

  always_comb begin
    exp_max = (x[30:23] == 8'hFF);
    is_nan  = exp_max && (x[22:0] != 23'd0);
    is_inf  = exp_max && (x[22:0] == 23'd0);
    is_zero = (x[30:23] == 8'h00);
  end

endmodule

// File: rtl/fp32_round_pack.sv
// Normalises a 48-bit mantissa product, rounds to nearest even and packs an
// IEEE single, saturating to infinity on overflow and flushing underflow to zero.
module fp32_round_pack
  import fpau_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [47:0]       prod,
  output logic [31:0]       result
);

  logic [23:0]       mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [24:0]       mant_rnd;
  logic [23:0]       mant_fin;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_fin;

  always_comb begin
    if (prod[47]) begin
      mant     = prod[47:24];
      guard    = prod[23];
      sticky   = |prod[22:0];
      exp_norm = exp_in + 10'sd1;
    end else begin
      mant     = prod[46:23];
      guard    = prod[22];
      sticky   = |prod[21:0];
      exp_norm = exp_in;
    end

    // Ties go to the even mantissa; a carry out of the top bit renormalises.
    round_up = guard && (sticky || mant[0]);
    mant_rnd = {1'b0, mant} + {24'd0, round_up};
    if (mant_rnd[24]) begin
      mant_fin = mant_rnd[24:1];
      exp_fin  = exp_norm + 10'sd1;
    end else begin
      mant_fin = mant_rnd[23:0];
      exp_fin  = exp_norm;
    end

    if (exp_fin >= 10'sd255) begin
      result = {sign, FP_INF_MAG};
    end else if (exp_fin <= 10'sd0) begin
      result = FP_ZERO;
    end else begin
      result = {sign, exp_fin[7:0], mant_fin[22:0]};
    end
  end

endmodule

// File: rtl/fp32_mul_seq.sv
// Sequential IEEE single multiplier: one shift-add mantissa bit per clock,
// then a single normalise/round cycle, with valid/ready on both sides.
module fp32_mul_seq
  import fpau_pkg::*;
#(
  parameter int MANT_W   = fpau_pkg::MANT_W,
  parameter int EXP_BIAS = fpau_pkg::EXP_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] S,
  output logic        busy
);

  localparam int CNT_W = $clog2(MANT_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MANT_W-1:0]   mcand_q, mcand_d;
  logic [2*MANT_W-1:0] prod_q, prod_d;
  logic signed [9:0]   exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [31:0]         s_q, s_d;

  logic              a_nan, a_inf, a_zero;
  logic              b_nan, b_inf, b_zero;
  logic              in_sign;
  logic [MANT_W:0]   acc_sum;
  logic [31:0]       rounded;

  checkspecial u_check_a (.x(A), .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
  checkspecial u_check_b (.x(B), .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));

  fp32_round_pack u_round (
    .sign   (sign_q),
    .exp_in (exp_q),
    .prod   (prod_q),
    .result (rounded)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    s_d     = s_q;

    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    in_sign = A[31] ^ B[31];
    // Upper half accumulates; the multiplier drains out of the lower half.
    acc_sum = {1'b0, prod_q[2*MANT_W-1:MANT_W]} +
              (prod_q[0] ? {1'b0, mcand_q} : {(MANT_W+1){1'b0}});

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sign_d = in_sign;
          if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            s_d     = FP_NAN;
            state_d = DONE;
          end else if (a_inf || b_inf) begin
            s_d     = {in_sign, FP_INF_MAG};
            state_d = DONE;
          end else if (a_zero || b_zero) begin
            s_d     = FP_ZERO;
            state_d = DONE;
          end else begin
            mcand_d = {1'b1, A[22:0]};
            prod_d  = {{MANT_W{1'b0}}, 1'b1, B[22:0]};
            exp_d   = 10'({2'b00, A[30:23]}) + 10'({2'b00, B[30:23]}) - 10'(EXP_BIAS);
            cnt_d   = '0;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        busy   = 1'b1;
        prod_d = {acc_sum, prod_q[MANT_W-1:1]};
        if (cnt_q == CNT_W'(MANT_W - 1)) begin
          cnt_d   = '0;
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NORM: begin
        busy    = 1'b1;
        s_d     = rounded;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      s_q     <= FP_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      s_q     <= s_d;
    end
  end

  assign S = s_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed bench for fp32_mul_seq: reset, normal products, specials, range
// limits, back-pressure and reset during an operation.
module tb_fp32_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_s;
  logic        busy;

  int total;
  int bad;

  fp32_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (op_a),
    .B         (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (res_s),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts at a negedge with the DUT idle; returns at a negedge with it idle.
  // lat counts clocks from the accept cycle to the first cycle with out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] s, output int lat);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    s = res_s;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 32'h0;
    op_b      = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res_s !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset: in_ready=%b out_valid=%b busy=%b S=%h required 1 0 0 00000000",
               in_ready, out_valid, busy, res_s);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int busy_bad;
    in_valid = 1'b1;
    op_a     = 32'h40000000;
    op_b     = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    busy_bad = 0;
    while (!out_valid && lat < 60) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) busy_bad++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 26) begin
      bad++;
      $display("[TB] FAIL basic_latency: got %0d required 26", lat);
    end
    total++;
    if (busy_bad !== 0) begin
      bad++;
      $display("[TB] FAIL basic_busy: %0d cycles with busy low or in_ready high, required 0", busy_bad);
    end
    total++;
    if (res_s !== 32'h40C00000) begin
      bad++;
      $display("[TB] FAIL basic_2x3: got %h required 40C00000", res_s);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_busy_done: got %b required 0", busy);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_rounding();
    logic [31:0] s;
    int lat;
    run_op(32'h3F800001, 32'h3F800001, s, lat);
    total++;
    if (s !== 32'h3F800002 || lat !== 26) begin
      bad++;
      $display("[TB] FAIL round_nearest: got %h lat %0d required 3F800002 lat 26", s, lat);
    end
    run_op(32'h3FC00000, 32'h3FC00000, s, lat);
    total++;
    if (s !== 32'h40100000 || lat !== 26) begin
      bad++;
      $display("[TB] FAIL norm_bit47: got %h lat %0d required 40100000 lat 26", s, lat);
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vexp [8];
    int          vlat [8];
    logic [31:0] s;
    int lat;
    va[0] = 32'h7F800000; vb[0] = 32'h00000000; vexp[0] = 32'h7FFFFFFF; vlat[0] = 1;
    va[1] = 32'hFF800000; vb[1] = 32'h40000000; vexp[1] = 32'hFF800000; vlat[1] = 1;
    va[2] = 32'h7FC00000; vb[2] = 32'h3F800000; vexp[2] = 32'h7FFFFFFF; vlat[2] = 1;
    va[3] = 32'h80000000; vb[3] = 32'h40000000; vexp[3] = 32'h00000000; vlat[3] = 1;
    va[4] = 32'h7F000000; vb[4] = 32'h7F000000; vexp[4] = 32'h7F800000; vlat[4] = 26;
    va[5] = 32'hFF000000; vb[5] = 32'h7F000000; vexp[5] = 32'hFF800000; vlat[5] = 26;
    va[6] = 32'h00800000; vb[6] = 32'h00800000; vexp[6] = 32'h00000000; vlat[6] = 26;
    va[7] = 32'h00400000; vb[7] = 32'h40000000; vexp[7] = 32'h00000000; vlat[7] = 1;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], s, lat);
      total++;
      if (s !== vexp[i] || lat !== vlat[i]) begin
        bad++;
        $display("[TB] FAIL special_%0d %h*%h: got %h lat %0d required %h lat %0d",
                 i, va[i], vb[i], s, lat, vexp[i], vlat[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    logic [31:0] held;
    int lat;
    int stall_bad;
    in_valid = 1'b1;
    op_a     = 32'h40000000;
    op_b     = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    held = res_s;
    total++;
    if (held !== 32'h40C00000) begin
      bad++;
      $display("[TB] FAIL bp_first: got %h required 40C00000", held);
    end
    stall_bad = 0;
    in_valid  = 1'b1;
    op_a      = 32'h3F800000;
    op_b      = 32'h3F800000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || res_s !== 32'h40C00000 || in_ready !== 1'b0) stall_bad++;
    end
    in_valid = 1'b0;
    total++;
    if (stall_bad !== 0) begin
      bad++;
      $display("[TB] FAIL bp_stall: %0d unstable cycles required 0", stall_bad);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    run_op(32'h3FC00000, 32'h3FC00000, s, lat);
    total++;
    if (s !== 32'h40100000 || lat !== 26) begin
      bad++;
      $display("[TB] FAIL bp_next: got %h lat %0d required 40100000 lat 26", s, lat);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] s;
    int lat;
    in_valid = 1'b1;
    op_a     = 32'h40000000;
    op_b     = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res_s !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid: in_ready=%b out_valid=%b busy=%b S=%h required 1 0 0 00000000",
               in_ready, out_valid, busy, res_s);
    end
    run_op(32'h40000000, 32'h40400000, s, lat);
    total++;
    if (s !== 32'h40C00000 || lat !== 26) begin
      bad++;
      $display("[TB] FAIL reset_mid_after: got %h lat %0d required 40C00000 lat 26", s, lat);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
